// File: rtl/test_pulse_emitter_if.sv
// Handshake/config/status bundle for the test pulse emitter.
// The master drives control and config; the slave (the emitter) drives status.
interface test_pulse_emitter_if #(
  parameter int CNT_W = 16,
  parameter int WID_W = 4
);
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] nburst;
  logic [WID_W-1:0] width;
  logic [1:0]       gap;
  logic             pulse_out;
  logic             marker;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_sent;

  modport master (
    output start, stop, period, nburst, width, gap,
    input  pulse_out, marker, busy, done, pulses_sent
  );

  modport slave (
    input  start, stop, period, nburst, width, gap,
    output pulse_out, marker, busy, done, pulses_sent
  );
endinterface

// File: rtl/test_pulse_emitter.sv
// Burst generator of primary/secondary test pulses for detector self-test.
// Optional per-period LFSR jitter is enabled with TESTPULSE_JITTER_EN.
module test_pulse_emitter #(
  parameter int CNT_W = 16,
  parameter int WID_W = 4
) (
  input logic                 clk,
  input logic                 reset,
  test_pulse_emitter_if.slave bus
);

  localparam int CW = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRI_HIGH,
    PRI_LOW,
    SEC_HIGH,
    TAIL_LOW,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WID_W-1:0] w_q, w_d;
  logic [1:0]       gap_q, gap_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] nb_q, nb_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             pulse_q, pulse_d;
  logic             marker_q, marker_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             new_pri;
  logic [2:0]       extra;

  logic [WID_W-1:0] w_in;
  logic [CNT_W-1:0] w_ext;
  logic [CNT_W-1:0] pmin;
  logic [CNT_W-1:0] p_in;
  logic [CW-1:0]    peff;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    sec_c;
  logic [CNT_W-1:0] sent_inc;
  logic             last;

  // Effective config computed from the live inputs, latched only on accept
  always_comb begin
    w_in  = (bus.width == '0) ? WID_W'(1) : bus.width;
    w_ext = CNT_W'(w_in);
    if (bus.gap == 2'd0)
      pmin = w_ext + CNT_W'(1);
    else
      pmin = w_ext + CNT_W'(bus.gap) + CNT_W'(2);
    p_in = (bus.period < pmin) ? pmin : bus.period;
  end

  always_comb begin
    peff     = CW'(per_q) + CW'(extra);
    cnt_nx   = cnt_q + CW'(1);
    sec_c    = CW'(w_q) + CW'(gap_q);
    sent_inc = (&sent_q) ? sent_q : sent_q + CNT_W'(1);
    last     = (nb_q != '0) && (sent_q == nb_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    gap_d   = gap_q;
    per_d   = per_q;
    nb_d    = nb_q;
    sent_d  = sent_q;
    new_pri = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PRI_HIGH;
          cnt_d   = '0;
          w_d     = w_in;
          gap_d   = bus.gap;
          per_d   = p_in;
          nb_d    = bus.nburst;
          sent_d  = CNT_W'(1);
          new_pri = 1'b1;
        end
      end
      PRI_HIGH: begin
        if (bus.stop) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_nx;
          if (cnt_nx >= CW'(w_q))
            state_d = PRI_LOW;
        end
      end
      SEC_HIGH: begin
        if (bus.stop) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_nx;
          state_d = TAIL_LOW;
        end
      end
      PRI_LOW, TAIL_LOW: begin
        if (bus.stop) begin
          state_d = DONE;
        end else if (state_q == PRI_LOW && gap_q != 2'd0
                     && cnt_nx == sec_c) begin
          cnt_d   = cnt_nx;
          state_d = SEC_HIGH;
        end else if (cnt_nx == peff) begin
          if (last) begin
            state_d = DONE;
          end else begin
            state_d = PRI_HIGH;
            cnt_d   = '0;
            sent_d  = sent_inc;
            new_pri = 1'b1;
          end
        end else begin
          cnt_d = cnt_nx;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops
  always_comb begin
    pulse_d  = (state_d == PRI_HIGH) || (state_d == SEC_HIGH);
    marker_d = (state_d == PRI_HIGH) && (cnt_d == '0);
    busy_d   = (state_d == PRI_HIGH) || (state_d == PRI_LOW)
            || (state_d == SEC_HIGH) || (state_d == TAIL_LOW);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_q      <= WID_W'(1);
      gap_q    <= 2'd0;
      per_q    <= CNT_W'(2);
      nb_q     <= '0;
      sent_q   <= '0;
      pulse_q  <= 1'b0;
      marker_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      gap_q    <= gap_d;
      per_q    <= per_d;
      nb_q     <= nb_d;
      sent_q   <= sent_d;
      pulse_q  <= pulse_d;
      marker_q <= marker_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef TESTPULSE_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  extra_q, extra_d;
  logic        fb;

  // Each primary takes the current LFSR low bits as its extra tail length
  always_comb begin
    fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = lfsr_q;
    extra_d = extra_q;
    if (new_pri) begin
      extra_d = lfsr_q[2:0];
      lfsr_d  = {lfsr_q[14:0], fb};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= 16'hACE1;
      extra_q <= 3'd0;
    end else begin
      lfsr_q  <= lfsr_d;
      extra_q <= extra_d;
    end
  end

  assign extra = extra_q;
`else
  assign extra = 3'd0;
`endif

  assign bus.pulse_out   = pulse_q;
  assign bus.marker      = marker_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;

endmodule
